// File: rtl/regfile_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg: shared widths and the write-request record used by the register
// file write-port arbiter and its LU result FIFO.
//   REG_ADDR_W / DATA_W / REG_COUNT : register file geometry
//   ZERO_REG                        : hard-wired zero register, never written
//   wr_req_t                        : one pending register write {dest, val}
// ----------------------------------------------------------------------------
package mips_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int REG_COUNT  = 32;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] dest;
      logic [DATA_W-1:0]     val;
   } wr_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_if: bundles every non-clock signal of the arbiter.
//   WB request   : wb_en, wb_dest, wb_val
//   LU result    : lu_valid, lu_dest, lu_val, lu_ready
//   LU issue     : issue_lu, issue_dest
//   ID hazard    : src1, src2, id_dest, stall
//   WB control   : wb_hold
//   RF write     : rf_we, rf_dest, rf_val
// master = pipeline/LU side driving requests, slave = the arbiter.
// ----------------------------------------------------------------------------
interface regfile_wb_arbiter_if;
   import mips_pkg::*;

   logic                  wb_en;
   logic [REG_ADDR_W-1:0] wb_dest;
   logic [DATA_W-1:0]     wb_val;
   logic                  lu_valid;
   logic                  lu_ready;
   logic [REG_ADDR_W-1:0] lu_dest;
   logic [DATA_W-1:0]     lu_val;
   logic                  issue_lu;
   logic [REG_ADDR_W-1:0] issue_dest;
   logic [REG_ADDR_W-1:0] src1;
   logic [REG_ADDR_W-1:0] src2;
   logic [REG_ADDR_W-1:0] id_dest;
   logic                  stall;
   logic                  wb_hold;
   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_dest;
   logic [DATA_W-1:0]     rf_val;

   modport master (
      output wb_en, wb_dest, wb_val, lu_valid, lu_dest, lu_val,
             issue_lu, issue_dest, src1, src2, id_dest,
      input  lu_ready, stall, wb_hold, rf_we, rf_dest, rf_val
   );

   modport slave (
      input  wb_en, wb_dest, wb_val, lu_valid, lu_dest, lu_val,
             issue_lu, issue_dest, src1, src2, id_dest,
      output lu_ready, stall, wb_hold, rf_we, rf_dest, rf_val
   );

endinterface

// File: rtl/regfile_wb_arbiter_lu_result_fifo.sv
// ----------------------------------------------------------------------------
// lu_result_fifo: DEPTH-entry FIFO of LU write requests.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : enqueue din; taken when not full, or when full and popping
//   pop/dout : dout is the head; pop removes it
//   empty/full : occupancy flags, derived from state only
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ----------------------------------------------------------------------------
module lu_result_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  logic    pop,
   input  wr_req_t din,
   output wr_req_t dout,
   output logic    empty,
   output logic    full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wr_req_t         mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW:0]     count_q;
   logic            push_ok_s;
   logic            pop_ok_s;

   assign empty     = (count_q == (AW+1)'(0));
   assign full      = (count_q == (AW+1)'(DEPTH));
   // A full FIFO still takes a push in the same cycle its head leaves.
   assign push_ok_s = push & (~full | pop);
   assign pop_ok_s  = pop & ~empty;
   assign dout      = mem_q[rd_ptr_q];

   // Storage array; contents need no reset because count_q gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= AW'(0);
         rd_ptr_q <= AW'(0);
         count_q  <= (AW+1)'(0);
      end else begin
         if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter: shares the single register-file write port between the
// pipeline WB stage and the multi-cycle LU (mul/div).
//   clk, rst : clock, synchronous active-high reset
//   bus      : regfile_wb_arbiter_if.slave (WB request, LU result, issue,
//              ID hazard sources, stall, wb_hold, RF write port)
// WB has priority unless wb_hold is set; LU results queue in lu_result_fifo.
// A head that waits MAX_WAIT cycles forces a one-cycle wb_hold so it drains.
// A 32-bit busy scoreboard tracks registers awaiting LU results and drives
// the combinational ID stall.
// Optional macro LU_BYPASS_EN: with the FIFO empty and WB not writing, an
// arriving LU result goes straight to the write port in the same cycle.
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
   import mips_pkg::*;
#(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_wb_arbiter_if.slave  bus
);

   // Counter must reach MAX_WAIT: it keeps counting in the cycle wb_hold is set up.
   localparam int WW = $clog2(MAX_WAIT + 1);

   wr_req_t               head_s, lu_req_s, wb_req_s, sel_s;
   logic                  empty_s, full_s, push_s, pop_s;
   logic                  wb_win_s, bypass_s, sel_valid_s;
   logic                  clr_en_s, set_en_s;
   logic [REG_ADDR_W-1:0] clr_dest_s;
   logic [WW-1:0]         wait_q, wait_d;
   logic                  wb_hold_q, wb_hold_d;
   logic [REG_COUNT-1:0]  busy_q, busy_d;

   assign lu_req_s = '{dest: bus.lu_dest, val: bus.lu_val};
   assign wb_req_s = '{dest: bus.wb_dest, val: bus.wb_val};
   assign wb_win_s = bus.wb_en & ~wb_hold_q;
   assign pop_s    = ~wb_win_s & ~empty_s;

`ifdef LU_BYPASS_EN
   assign bypass_s = empty_s & ~wb_win_s & bus.lu_valid;
`else
   assign bypass_s = 1'b0;
`endif

   // A bypassed result never enters the FIFO.
   assign push_s       = bus.lu_valid & ~bypass_s & (~full_s | pop_s);
   assign bus.lu_ready = ~full_s;

   lu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .din   (lu_req_s),
      .dout  (head_s),
      .empty (empty_s),
      .full  (full_s)
   );

   // Write-port selection: WB, then FIFO head, then (optionally) bypass.
   always_comb begin
      sel_s       = '0;
      sel_valid_s = 1'b0;
      if (wb_win_s) begin
         sel_s       = wb_req_s;
         sel_valid_s = 1'b1;
      end else if (~empty_s) begin
         sel_s       = head_s;
         sel_valid_s = 1'b1;
      end else if (bypass_s) begin
         sel_s       = lu_req_s;
         sel_valid_s = 1'b1;
      end else begin
         sel_s       = '0;
         sel_valid_s = 1'b0;
      end
   end

   assign bus.rf_we   = sel_valid_s & (sel_s.dest != ZERO_REG);
   assign bus.rf_dest = sel_s.dest;
   assign bus.rf_val  = sel_s.val;

   // Head wait counter and the one-cycle wb_hold it triggers.
   always_comb begin
      wait_d    = wait_q;
      wb_hold_d = 1'b0;
      if (empty_s | pop_s) begin
         wait_d = WW'(0);
      end else begin
         wait_d    = wait_q + WW'(1);
         wb_hold_d = (wait_q == WW'(MAX_WAIT - 1));
      end
   end

   assign clr_en_s   = pop_s | bypass_s;
   assign clr_dest_s = pop_s ? head_s.dest : bus.lu_dest;
   assign set_en_s   = bus.issue_lu & (bus.issue_dest != ZERO_REG);

   // Scoreboard next state: a set on the same register overrides a clear.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < REG_COUNT; i++) begin
         busy_d[i] = (set_en_s & (bus.issue_dest == REG_ADDR_W'(i))) |
                     (busy_q[i] & ~(clr_en_s & (clr_dest_s == REG_ADDR_W'(i))));
      end
      busy_d[0] = 1'b0;
   end

   assign bus.stall   = busy_q[bus.src1] | busy_q[bus.src2] | busy_q[bus.id_dest];
   assign bus.wb_hold = wb_hold_q;

   // State registers for wait counter, hold flag and scoreboard.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_q    <= WW'(0);
         wb_hold_q <= 1'b0;
         busy_q    <= '0;
      end else begin
         wait_q    <= wait_d;
         wb_hold_q <= wb_hold_d;
         busy_q    <= busy_d;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter: directed bench for regfile_wb_arbiter (DEPTH=2,
// MAX_WAIT=4). Expected RF writes go into a queue when stimulus is applied;
// a negedge monitor pops and compares on every rf_we. Control outputs
// (stall, wb_hold, lu_ready, rf_we) are compared directly. Honours
// LU_BYPASS_EN where the expected timing differs.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
   import mips_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   wr_req_t exp_q[$];
   wr_req_t mon_e;

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [4:0] d, input logic [31:0] v);
      wr_req_t t;
      t.dest = d;
      t.val  = v;
      exp_q.push_back(t);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      bus.wb_en = 1'b0;  bus.wb_dest = 5'd0;  bus.wb_val = 32'h0;
      bus.lu_valid = 1'b0; bus.lu_dest = 5'd0; bus.lu_val = 32'h0;
      bus.issue_lu = 1'b0; bus.issue_dest = 5'd0;
      bus.src1 = 5'd0; bus.src2 = 5'd0; bus.id_dest = 5'd0;
   endtask

   // Scoreboard monitor: every write outside reset must match the queue head.
   always @(negedge clk) begin
      if (rst !== 1'b1 && bus.rf_we === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rf_write: got dest=%0d val=%0h, required no write",
                     bus.rf_dest, bus.rf_val);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.rf_dest !== mon_e.dest || bus.rf_val !== mon_e.val) begin
               failures++;
               $display("FAIL rf_write: got dest=%0d val=%0h, required dest=%0d val=%0h",
                        bus.rf_dest, bus.rf_val, mon_e.dest, mon_e.val);
            end
         end
      end
   end

   // Run-time bound.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   // Directed stimulus.
   initial begin
      rst = 1'b1;
      idle_inputs();
      step(); step();
      rst = 1'b0;

      // Reset with one queued entry and busy[5] set.
      bus.issue_lu = 1'b1; bus.issue_dest = 5'd5;
      bus.wb_en = 1'b1; bus.wb_dest = 5'd1; bus.wb_val = 32'hA1;
      bus.lu_valid = 1'b1; bus.lu_dest = 5'd12; bus.lu_val = 32'hBEEF;
      push_exp(5'd1, 32'hA1);
      settle(); chk("lu_ready_empty", {31'd0, bus.lu_ready}, 32'd1);
      step();
      idle_inputs();
      bus.wb_en = 1'b1; bus.wb_dest = 5'd1; bus.wb_val = 32'hA1; bus.src1 = 5'd5;
      push_exp(5'd1, 32'hA1);
      settle(); chk("stall_busy5", {31'd0, bus.stall}, 32'd1);
      step();
      idle_inputs(); rst = 1'b1;
      step(); step();
      rst = 1'b0; bus.src1 = 5'd5;
      settle();
      chk("rst_stall", {31'd0, bus.stall}, 32'd0);
      chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
      chk("rst_wb_hold", {31'd0, bus.wb_hold}, 32'd0);
      chk("rst_lu_ready", {31'd0, bus.lu_ready}, 32'd1);
      step();

      // Idle-WB drain of an LU result for r7.
      idle_inputs(); bus.issue_lu = 1'b1; bus.issue_dest = 5'd7;
      step();
      idle_inputs(); bus.src1 = 5'd7;
      bus.lu_valid = 1'b1; bus.lu_dest = 5'd7; bus.lu_val = 32'hDEAD;
      push_exp(5'd7, 32'hDEAD);
      settle(); chk("drain_stall_before", {31'd0, bus.stall}, 32'd1);
`ifdef LU_BYPASS_EN
      chk("drain_bypass_we", {31'd0, bus.rf_we}, 32'd1);
`else
      chk("drain_no_write_yet", {31'd0, bus.rf_we}, 32'd0);
`endif
      step();
      idle_inputs(); bus.src1 = 5'd7;
      settle();
`ifdef LU_BYPASS_EN
      chk("drain_stall_after", {31'd0, bus.stall}, 32'd0);
      chk("drain_we_after", {31'd0, bus.rf_we}, 32'd0);
`else
      chk("drain_stall_during_write", {31'd0, bus.stall}, 32'd1);
      chk("drain_write_cycle", {31'd0, bus.rf_we}, 32'd1);
`endif
      step();
      idle_inputs(); bus.src1 = 5'd7;
      settle(); chk("drain_stall_cleared", {31'd0, bus.stall}, 32'd0);
      step();

      // Contention: WB r3 every cycle, one LU result for r9.
      for (int k = 0; k <= 6; k++) begin
         idle_inputs();
         bus.wb_en = 1'b1; bus.wb_dest = 5'd3; bus.wb_val = 32'h11; bus.src1 = 5'd9;
         if (k == 0) begin
            bus.lu_valid = 1'b1; bus.lu_dest = 5'd9; bus.lu_val = 32'h99;
            bus.issue_lu = 1'b1; bus.issue_dest = 5'd9;
         end
         if (k == 5) push_exp(5'd9, 32'h99);
         else        push_exp(5'd3, 32'h11);
         settle();
         chk($sformatf("cont_hold_k%0d", k), {31'd0, bus.wb_hold}, {31'd0, (k == 5)});
         if (k == 5) chk("cont_stall_k5", {31'd0, bus.stall}, 32'd1);
         step();
      end
      idle_inputs(); bus.src1 = 5'd9;
      settle(); chk("cont_stall_cleared", {31'd0, bus.stall}, 32'd0);
      step();

      // Full FIFO: two results queued behind WB, third refused, push on pop kept.
      for (int k = 0; k <= 16; k++) begin
         idle_inputs();
         bus.wb_en = 1'b1; bus.wb_dest = 5'd2; bus.wb_val = 32'h22;
         case (k)
            0: begin bus.lu_valid = 1'b1; bus.lu_dest = 5'd10; bus.lu_val = 32'hA0A0; end
            1: begin bus.lu_valid = 1'b1; bus.lu_dest = 5'd11; bus.lu_val = 32'hB1B1; end
            2: begin bus.lu_valid = 1'b1; bus.lu_dest = 5'd13; bus.lu_val = 32'hC3C3; end
            5: begin bus.lu_valid = 1'b1; bus.lu_dest = 5'd14; bus.lu_val = 32'hD4D4; end
            default: bus.lu_valid = 1'b0;
         endcase
         case (k)
            5:       push_exp(5'd10, 32'hA0A0);
            10:      push_exp(5'd11, 32'hB1B1);
            15:      push_exp(5'd14, 32'hD4D4);
            default: push_exp(5'd2, 32'h22);
         endcase
         settle();
         chk($sformatf("full_hold_k%0d", k), {31'd0, bus.wb_hold},
             {31'd0, (k == 5 || k == 10 || k == 15)});
         if (k == 1)  chk("full_ready_one", {31'd0, bus.lu_ready}, 32'd1);
         if (k == 2)  chk("full_ready_two", {31'd0, bus.lu_ready}, 32'd0);
         if (k == 6)  chk("full_ready_after_pushpop", {31'd0, bus.lu_ready}, 32'd0);
         if (k == 11) chk("full_ready_one_left", {31'd0, bus.lu_ready}, 32'd1);
         step();
      end

      // Zero register is never busy and never written.
      idle_inputs();
      bus.issue_lu = 1'b1; bus.issue_dest = 5'd0;
      bus.lu_valid = 1'b1; bus.lu_dest = 5'd0; bus.lu_val = 32'h55;
      settle();
      chk("zero_stall", {31'd0, bus.stall}, 32'd0);
      chk("zero_lu_we", {31'd0, bus.rf_we}, 32'd0);
      step();
      idle_inputs(); bus.wb_en = 1'b1; bus.wb_dest = 5'd0; bus.wb_val = 32'h77;
      settle();
      chk("zero_wb_we", {31'd0, bus.rf_we}, 32'd0);
      chk("zero_stall_after_issue", {31'd0, bus.stall}, 32'd0);
      step();
      idle_inputs();
      settle(); chk("zero_head_we", {31'd0, bus.rf_we}, 32'd0);
      step();
      settle();
      chk("zero_drained_ready", {31'd0, bus.lu_ready}, 32'd1);
      chk("zero_drained_we", {31'd0, bus.rf_we}, 32'd0);
      step();

      // Set/clear collision on r4: set wins.
      idle_inputs(); bus.issue_lu = 1'b1; bus.issue_dest = 5'd4;
      step();
      idle_inputs();
      bus.lu_valid = 1'b1; bus.lu_dest = 5'd4; bus.lu_val = 32'h44;
      push_exp(5'd4, 32'h44);
`ifdef LU_BYPASS_EN
      bus.issue_lu = 1'b1; bus.issue_dest = 5'd4;
`endif
      step();
      idle_inputs();
`ifndef LU_BYPASS_EN
      bus.issue_lu = 1'b1; bus.issue_dest = 5'd4;
`endif
      step();
      idle_inputs(); bus.src1 = 5'd4;
      settle(); chk("collision_set_wins", {31'd0, bus.stall}, 32'd1);
      step(); step(); step();

      chk("pending_writes", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
